// File: rtl/store_unit.sv
// store_unit: narrows a register value to byte/half/word lanes and
// performs a request/acknowledge write with AdES and bus-error detection.
module store_unit #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_size,
    output logic        st_done,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    output logic        exc_valid,
    output logic [1:0]  exc_code,
    output logic [31:0] exc_badvaddr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    localparam logic [15:0] LP_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic [1:0]  LP_ADES = 2'b01;
    localparam logic [1:0]  LP_BUSE = 2'b10;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [31:0] r_baddr;
    logic        r_done;
    logic        r_req;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_exc_valid;
    logic [1:0]  r_exc_code;
    logic [31:0] r_exc_badvaddr;

    logic        w_hs;
    logic        w_bad;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;

    assign st_ready     = (r_state == S_IDLE);
    assign w_hs         = st_valid && st_ready;
    assign st_done      = r_done;
    assign mem_req      = r_req;
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign mem_be       = r_be;
    assign exc_valid    = r_exc_valid;
    assign exc_code     = r_exc_code;
    assign exc_badvaddr = r_exc_badvaddr;

    // Lane replication, byte enables and alignment check for the offered store
    always_comb begin
        w_wdata = '0;
        w_be    = '0;
        w_bad   = 1'b0;
        case (st_size)
            2'b00: begin
                w_wdata = {4{st_data[7:0]}};
                w_be    = 4'b0001 << st_addr[1:0];
            end
            2'b01: begin
                w_wdata = {2{st_data[15:0]}};
                w_be    = st_addr[1] ? 4'b1100 : 4'b0011;
                w_bad   = st_addr[0];
            end
            2'b10: begin
                w_wdata = st_data;
                w_be    = 4'b1111;
                w_bad   = |st_addr[1:0];
            end
            default: w_bad = 1'b1;
        endcase
    end

    // Control FSM with registered memory-side and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_baddr        <= '0;
            r_done         <= 1'b0;
            r_req          <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_be           <= '0;
            r_exc_valid    <= 1'b0;
            r_exc_code     <= '0;
            r_exc_badvaddr <= '0;
        end else begin
            r_done      <= 1'b0;
            r_exc_valid <= 1'b0;
            r_exc_code  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        if (w_bad) begin
                            r_state        <= S_RESP;
                            r_exc_valid    <= 1'b1;
                            r_exc_code     <= LP_ADES;
                            r_exc_badvaddr <= st_addr;
                        end else begin
                            r_state <= S_REQ;
                            r_req   <= 1'b1;
                            r_cnt   <= '0;
                            r_baddr <= st_addr;
                            r_addr  <= {st_addr[31:2], 2'b00};
                            r_wdata <= w_wdata;
                            r_be    <= w_be;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        r_state <= S_RESP;
                        r_req   <= 1'b0;
                        r_wdata <= '0;
                        r_be    <= '0;
                        r_done  <= 1'b1;
                    end else if (r_cnt == LP_LAST) begin
                        r_state        <= S_RESP;
                        r_req          <= 1'b0;
                        r_wdata        <= '0;
                        r_be           <= '0;
                        r_exc_valid    <= 1'b1;
                        r_exc_code     <= LP_BUSE;
                        r_exc_badvaddr <= r_baddr;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_RESP: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
